// File: rtl/mp_calc_seq.sv
// Sequential unsigned ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, and two-stage composite expressions with a busy/done handshake.
module mp_calc_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       opcode,
  input  logic             compute,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] im,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dz,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opd;
  logic             r_div;

  logic [WIDTH:0]   w_ab_add, w_ab_sub, w_cd_add, w_cd_sub;
  logic [WIDTH:0]   w_p, w_q;
  logic             w_s1_ovf;
  logic [WIDTH:0]   w_sum, w_rs;
  logic [WIDTH-1:0] w_rdiff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_next, w_lo_next;

  // Stage-1 operands carry their carry/borrow in the extra top bit.
  assign w_ab_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_ab_sub = {1'b0, r_a} - {1'b0, r_b};
  assign w_cd_add = {1'b0, r_c} + {1'b0, r_d};
  assign w_cd_sub = {1'b0, r_c} - {1'b0, r_d};
  assign w_p      = (r_op == 3'd6) ? w_ab_add : w_ab_sub;
  assign w_q      = (r_op == 3'd6) ? w_cd_add : w_cd_sub;
  assign w_s1_ovf = w_p[WIDTH] | w_q[WIDTH];

  // Shared iterative unit: r_lo holds multiplier/dividend shifting out and the
  // product-low/quotient shifting in; r_hi is the partial product or remainder.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_rs    = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_rs >= {1'b0, r_opd});
  assign w_rdiff = w_rs[WIDTH-1:0] - r_opd;

  assign w_hi_next = r_div ? (w_ge ? w_rdiff : w_rs[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign w_lo_next = r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opd   <= '0;
      r_div   <= 1'b0;
      out     <= '0;
      out_hi  <= '0;
      im      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (compute) begin
            r_a    <= A;
            r_b    <= B;
            r_c    <= C;
            r_d    <= D;
            r_op   <= opcode;
            out    <= '0;
            out_hi <= '0;
            im     <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            r_hi   <= '0;
            r_lo   <= A;
            r_opd  <= B;
            r_div  <= (opcode == 3'd3);
            r_cnt  <= CW'(WIDTH);
            r_state <= (opcode == 3'd2 || opcode == 3'd3) ? S_ITER : S_PRE;
          end
        end
        S_PRE: begin
          case (r_op)
            3'd0: begin
              out     <= w_ab_add[WIDTH-1:0];
              ovf     <= w_ab_add[WIDTH];
              done    <= 1'b1;
              r_state <= S_DONE;
            end
            3'd1: begin
              out     <= w_ab_sub[WIDTH-1:0];
              ovf     <= w_ab_sub[WIDTH];
              done    <= 1'b1;
              r_state <= S_DONE;
            end
            3'd4, 3'd5, 3'd6: begin
              im      <= w_p[WIDTH-1:0];
              r_lo    <= w_p[WIDTH-1:0];
              r_opd   <= w_q[WIDTH-1:0];
              r_hi    <= '0;
              r_div   <= (r_op == 3'd5);
              r_cnt   <= CW'(WIDTH);
              ovf     <= w_s1_ovf;
              r_state <= S_ITER;
            end
            default: begin
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          endcase
        end
        S_ITER: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            out     <= w_lo_next;
            out_hi  <= w_hi_next;
            ovf     <= ovf | (!r_div && (|w_hi_next));
            dz      <= r_div && (r_opd == '0);
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_calc_seq.sv
// Scoreboard bench for mp_calc_seq: expected results queued at issue, popped on done.
module tb_mp_calc_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A = '0, B = '0, C = '0, D = '0;
  logic [2:0]   opcode = '0;
  logic         compute = 1'b0;
  logic [W-1:0] out, out_hi, im;
  logic         busy, done, ovf, dz, err;

  mp_calc_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D),
    .opcode(opcode), .compute(compute), .out(out), .out_hi(out_hi), .im(im),
    .busy(busy), .done(done), .ovf(ovf), .dz(dz), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic [W-1:0] im;
    logic         ovf;
    logic         dz;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, b, c, d);
    exp_t e;
    logic [W:0]    p, q;
    logic [2*W-1:0] prod;
    logic [W-1:0]  x, y;
    logic          s1;
    e = '{out: '0, hi: '0, im: '0, ovf: 1'b0, dz: 1'b0, err: 1'b0, lat: 1};
    x = a;
    y = b;
    s1 = 1'b0;
    if (op >= 3'd4 && op <= 3'd6) begin
      p = (op == 3'd6) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
      q = (op == 3'd6) ? ({1'b0, c} + {1'b0, d}) : ({1'b0, c} - {1'b0, d});
      s1 = p[W] | q[W];
      x = p[W-1:0];
      y = q[W-1:0];
      e.im = x;
    end
    case (op)
      3'd0: begin p = {1'b0, a} + {1'b0, b}; e.out = p[W-1:0]; e.ovf = p[W]; end
      3'd1: begin p = {1'b0, a} - {1'b0, b}; e.out = p[W-1:0]; e.ovf = p[W]; end
      3'd2, 3'd4, 3'd6: begin
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.out = prod[W-1:0];
        e.hi  = prod[2*W-1:W];
        e.ovf = s1 | (e.hi != '0);
        e.lat = (op == 3'd2) ? W : W + 1;
      end
      3'd3, 3'd5: begin
        if (y == '0) begin e.out = '1; e.hi = x; e.dz = 1'b1; end
        else begin e.out = x / y; e.hi = x % y; end
        e.ovf = s1;
        e.lat = (op == 3'd3) ? W : W + 1;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, c, d, input bit disturb);
    exp_t e;
    int   cyc;
    bit   seen;
    opcode = op; A = a; B = b; C = c; D = d;
    compute = 1'b1;
    sb.push_back(model(op, a, b, c, d));
    @(posedge clk); #1 compute = 1'b0;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 2 * W + 8) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("busy_e1", 64'(busy), 64'(1));
        if (op >= 3'd4 && op <= 3'd6) chk("im_e1", 64'(im), 64'(sb[0].im));
      end
      if (disturb && cyc == 3) begin
        A = 16'($urandom); B = 16'($urandom); C = 16'($urandom); D = 16'($urandom);
        opcode = 3'd0;
        compute = 1'b1;
      end
      if (disturb && cyc == 4) compute = 1'b0;
      if (done) seen = 1;
    end
    e = sb.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("out", 64'(out), 64'(e.out));
    chk("out_hi", 64'(out_hi), 64'(e.hi));
    chk("im", 64'(im), 64'(e.im));
    chk("flags_ovf_dz_err", 64'({ovf, dz, err}), 64'({e.ovf, e.dz, e.err}));
    chk("busy_done", 64'(busy), 64'(1));
    $display("op=%0d a=%h b=%h c=%h d=%h -> out=%h hi=%h im=%h ovf=%0b dz=%0b err=%0b cyc=%0d",
             op, a, b, c, d, out, out_hi, im, ovf, dz, err, cyc);
    for (int k = 0; k < (disturb ? 3 : 1); k++) begin
      @(posedge clk); #1;
      chk("idle_busy_done", 64'({busy, done}), 64'(0));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 chk("reset_outputs", {10'd0, out, out_hi, im, busy, done, ovf, dz, err}, 64'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 16'd2, 16'd2, 16'd0, 16'd0, 0);
    run_op(3'd0, 16'hFFFF, 16'd2, 16'd0, 16'd0, 0);
    run_op(3'd1, 16'd10, 16'd3, 16'd0, 16'd0, 0);
    run_op(3'd1, 16'd3, 16'd10, 16'd0, 16'd0, 0);
    run_op(3'd7, 16'd9, 16'd9, 16'd9, 16'd9, 0);
    run_op(3'd2, 16'd5, 16'd5, 16'd0, 16'd0, 0);
    run_op(3'd2, 16'h1000, 16'h0100, 16'd0, 16'd0, 0);
    run_op(3'd3, 16'd8, 16'd2, 16'd0, 16'd0, 0);
    run_op(3'd3, 16'd7, 16'd0, 16'd0, 16'd0, 0);
    run_op(3'd4, 16'd10, 16'd8, 16'd6, 16'd4, 0);
    run_op(3'd5, 16'd20, 16'd10, 16'd8, 16'd2, 0);
    run_op(3'd6, 16'd3, 16'd3, 16'd2, 16'd2, 0);
    run_op(3'd2, 16'd1234, 16'd567, 16'd0, 16'd0, 1);

    // Abort a multiply mid-flight with reset.
    opcode = 3'd2; A = 16'd300; B = 16'd400; compute = 1'b1;
    @(posedge clk); #1 compute = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_outputs", {10'd0, out, out_hi, im, busy, done, ovf, dz, err}, 64'(0));
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'({busy, done}), 64'(0));
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 16'd100, 16'd23, 16'd0, 16'd0, 0);

    for (int i = 0; i < 12; i++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb, rc, rd;
      rop = 3'($urandom_range(0, 7));
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 16'($urandom); rd = 16'($urandom);
      if (i % 3 == 0) rb = 16'($urandom_range(0, 20));
      run_op(rop, ra, rb, rc, rd, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
